// File: rtl/max7219_ctrl_pkg.sv
// max7219_ctrl_pkg: MAX7219 register map, controller states and power-up table.
package max7219_ctrl_pkg;

    localparam logic [7:0] REG_NOOP      = 8'h00;
    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIM   = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;
    localparam int INIT_LEN = 6;

    typedef enum logic [2:0] {INIT_LOAD, IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

    function automatic logic [15:0] init_entry(input logic [2:0] i, input logic [2:0] scan,
                                               input logic [3:0] inten);
        return i == 3'd0 ? {REG_SHUTDOWN, 8'h00} :
               i == 3'd1 ? {REG_TEST, 8'h00} :
               i == 3'd2 ? {REG_DECODE, 8'h00} :
               i == 3'd3 ? {REG_SCANLIM, 5'b0, scan} :
               i == 3'd4 ? {REG_INTENSITY, 4'b0, inten} :
               i == 3'd5 ? {REG_SHUTDOWN, 8'h01} : {REG_NOOP, 8'h00};
    endfunction

endpackage

// File: rtl/max7219_rowbuf.sv
// max7219_rowbuf: 8x8 frame buffer with per-row dirty bits and lowest-dirty-row encoder.
module max7219_rowbuf (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       clr_en,
    input  logic [2:0] clr_row,
    input  logic       set_all,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_data,
    output logic       any_dirty,
    output logic [2:0] low_row
);
    logic [7:0] mem [8];
    logic [7:0] dirty;

    // A write in the same cycle as a clear keeps the row dirty so the new value is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '{default: 8'h00};
            dirty <= 8'hFF;
        end else begin
            if (wr_en) mem[wr_row] <= wr_data;
            dirty <= set_all ? 8'hFF :
                     (dirty & ~(clr_en ? 8'b1 << clr_row : 8'h00)) | (wr_en ? 8'b1 << wr_row : 8'h00);
        end
    end

    always_comb begin
        low_row = 3'd0;
        for (int i = 7; i >= 0; i--) low_row = dirty[i] ? 3'(i) : low_row;
    end

    assign rd_data   = mem[rd_row];
    assign any_dirty = |dirty;
endmodule

// File: rtl/max7219_ctrl.sv
// max7219_ctrl: runs the MAX7219 power-up sequence, then streams changed rows and
// intensity updates to the serial driver as (address, data) pairs.
module max7219_ctrl
    import max7219_ctrl_pkg::*;
#(
    parameter logic [3:0] INIT_INTENSITY = 4'h8,
    parameter logic [2:0] SCAN_LIMIT     = 3'd7,
    parameter logic [7:0] START_TIMEOUT  = 8'd15
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       init_req,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic [3:0] intensity,
    input  logic       intensity_we,
    input  logic       tx_busy,
    output logic       tx_str,
    output logic [7:0] tx_addr,
    output logic [7:0] tx_data,
    output logic       init_done,
    output logic       ready,
    output logic       err
);
    state_t     state, nxt;
    logic [2:0] idx, low_row;
    logic [3:0] int_reg;
    logic [7:0] cnt, rd_data;
    logic       int_pend, init_pend, any_dirty;
    logic       work, cap_int, cap_row, timeout, done, restart, init_more;

    max7219_rowbuf u_rowbuf (
        .clk(sys_clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .clr_en(cap_row), .clr_row(low_row), .set_all(restart), .rd_row(low_row),
        .rd_data(rd_data), .any_dirty(any_dirty), .low_row(low_row)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= INIT_LOAD;
        else     state <= nxt;
    end

    always_comb begin
        work      = int_pend || any_dirty;
        cap_int   = state == LOAD && int_pend;
        cap_row   = state == LOAD && !int_pend && any_dirty;
        timeout   = state == WAIT_BUSY && !tx_busy && cnt == START_TIMEOUT - 8'd1;
        done      = state == WAIT_DONE && !tx_busy;
        restart   = init_pend && (state == IDLE || done);
        init_more = !init_done && idx != 3'(INIT_LEN - 1);
        nxt       = state;
        case (state)
            INIT_LOAD: nxt = START;
            IDLE:      nxt = restart ? INIT_LOAD : work ? LOAD : IDLE;
            LOAD:      nxt = work ? START : IDLE;
            START:     nxt = WAIT_BUSY;
            WAIT_BUSY: nxt = tx_busy ? WAIT_DONE : timeout ? START : WAIT_BUSY;
            WAIT_DONE: nxt = !tx_busy ? ((restart || init_more) ? INIT_LOAD : IDLE) : WAIT_DONE;
            default:   nxt = INIT_LOAD;
        endcase
    end

    // Intensity written before table entry 4 is captured rides along with the init sequence.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            idx       <= 3'd0;
            int_reg   <= INIT_INTENSITY;
            int_pend  <= 1'b0;
            init_pend <= 1'b0;
            cnt       <= 8'd0;
            err       <= 1'b0;
            init_done <= 1'b0;
            tx_addr   <= 8'h00;
            tx_data   <= 8'h00;
        end else begin
            int_reg   <= intensity_we ? intensity : int_reg;
            int_pend  <= (intensity_we && !(!init_done && idx < 3'd4)) || (int_pend && !cap_int && !restart);
            init_pend <= init_req || (init_pend && !restart);
            cnt       <= state == START ? 8'd0 : state == WAIT_BUSY ? cnt + 8'd1 : cnt;
            err       <= restart ? 1'b0 : timeout ? 1'b1 : err;
            init_done <= restart ? 1'b0 : (done && !init_done && !init_more) ? 1'b1 : init_done;
            idx       <= restart ? 3'd0 : (done && init_more) ? idx + 3'd1 : idx;
            {tx_addr, tx_data} <= state == INIT_LOAD ? init_entry(idx, SCAN_LIMIT, int_reg) :
                                  cap_int ? {REG_INTENSITY, 4'b0, int_reg} :
                                  cap_row ? {REG_DIGIT0 + {5'b0, low_row}, rd_data} :
                                  {tx_addr, tx_data};
        end
    end

    assign tx_str = state == START;
    assign ready  = init_done && state == IDLE && !work && !init_pend;
endmodule

// File: tb/tb_max7219_ctrl.sv
// tb_max7219_ctrl: directed and random checks of max7219_ctrl against a display-level
// model: what the panel should show versus what the transferred pairs put on it.
module tb_max7219_ctrl;
    logic       sys_clk = 1'b0;
    logic       rst, init_req, wr_en, intensity_we, tx_busy;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic [3:0] intensity;
    logic       tx_str, init_done, ready, err;
    logic [7:0] tx_addr, tx_data;

    int         n_cmp = 0, n_bad = 0, resp_delay = 0;
    logic [15:0] q[$];
    logic [7:0] ref_buf[8], disp[8];
    logic [3:0] ref_int, disp_int;

    max7219_ctrl dut (
        .sys_clk(sys_clk), .rst(rst), .init_req(init_req), .wr_en(wr_en), .wr_row(wr_row),
        .wr_data(wr_data), .intensity(intensity), .intensity_we(intensity_we), .tx_busy(tx_busy),
        .tx_str(tx_str), .tx_addr(tx_addr), .tx_data(tx_data), .init_done(init_done),
        .ready(ready), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    initial forever begin
        @(negedge sys_clk);
        if (tx_str === 1'b1) q.push_back({tx_addr, tx_data});
    end

    // Serial driver: busy rises resp_delay cycles after a start, stays high three cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (tx_str === 1'b1) begin
                repeat (resp_delay) @(negedge sys_clk);
                tx_busy = 1'b1;
                repeat (3) @(negedge sys_clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic get_pair(output logic [15:0] p);
        int k = 0;
        while (q.size() == 0 && k < 300) begin tick(); k++; end
        if (q.size() == 0) begin
            chk("pair_timeout", 16'(q.size()), 16'd1);
            p = 16'hxxxx;
        end else begin
            p = q.pop_front();
            if (p[15:8] >= 8'd1 && p[15:8] <= 8'd8) disp[p[15:8] - 8'd1] = p[7:0];
            if (p[15:8] == 8'h0A) disp_int = p[3:0];
        end
    endtask

    task automatic expect_pair(input string tag, input logic [15:0] e);
        logic [15:0] p;
        get_pair(p);
        chk(tag, p, e);
    endtask

    task automatic expect_init();
        logic [15:0] seq[$];
        seq = '{16'h0C00, 16'h0F00, 16'h0900, {8'h0B, 5'b0, 3'd7}, {8'h0A, 4'b0, ref_int}, 16'h0C01};
        for (int r = 0; r < 8; r++) seq.push_back({8'(r + 1), ref_buf[r]});
        foreach (seq[i]) expect_pair($sformatf("init_pair%0d", i), seq[i]);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (ready !== 1'b1 && k < 600) begin tick(); k++; end
        chk("ready", 16'(ready), 16'd1);
    endtask

    task automatic wait_str();
        int k = 0;
        while (tx_str !== 1'b1 && k < 400) begin tick(); k++; end
        chk("str_seen", 16'(tx_str), 16'd1);
    endtask

    task automatic write_row(input logic [2:0] r, input logic [7:0] d);
        wr_en = 1'b1; wr_row = r; wr_data = d; ref_buf[r] = d;
    endtask

    task automatic check_display(input string tag);
        for (int r = 0; r < 8; r++) chk($sformatf("%s_row%0d", tag, r), 16'(disp[r]), 16'(ref_buf[r]));
        chk({tag, "_int"}, 16'(disp_int), 16'(ref_int));
    endtask

    initial begin
        int gap;
        logic [15:0] p;
        rst = 1'b1; init_req = 1'b0; wr_en = 1'b0; wr_row = 3'd0; wr_data = 8'h00;
        intensity = 4'h0; intensity_we = 1'b0;
        foreach (ref_buf[i]) begin ref_buf[i] = 8'h00; disp[i] = 8'hxx; end
        ref_int = 4'h8; disp_int = 4'hx;
        tick(); tick();
        chk("rst_str", 16'(tx_str), 16'd0);
        chk("rst_addr", 16'(tx_addr), 16'd0);
        chk("rst_data", 16'(tx_data), 16'd0);
        chk("rst_init_done", 16'(init_done), 16'd0);
        chk("rst_ready", 16'(ready), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        rst = 1'b0;
        expect_init();
        wait_ready();
        chk("init_done", 16'(init_done), 16'd1);

        write_row(3'd3, 8'hA5); tick();
        write_row(3'd0, 8'h3C); tick();
        wr_en = 1'b0;
        expect_pair("prio_row0", 16'h013C);
        expect_pair("prio_row3", 16'h04A5);
        wait_ready();

        write_row(3'd5, 8'h00); tick();
        wr_en = 1'b0; tick();
        write_row(3'd5, 8'h11); tick();
        wr_en = 1'b0;
        chk("str_after_load", 16'(tx_str), 16'd1);
        expect_pair("load_old", 16'h0600);
        expect_pair("load_new", 16'h0611);
        wait_ready();

        write_row(3'd6, 8'h66); tick();
        write_row(3'd7, 8'h77); tick();
        wr_en = 1'b0;
        wait_str(); tick();
        intensity_we = 1'b1; intensity = 4'hF; ref_int = 4'hF; tick();
        intensity_we = 1'b0;
        expect_pair("inflight_row6", 16'h0766);
        expect_pair("int_first", 16'h0A0F);
        expect_pair("then_row7", 16'h0877);
        wait_ready();

        resp_delay = 20;
        write_row(3'd4, 8'h5A); tick();
        wr_en = 1'b0;
        wait_str();
        gap = 0;
        do begin tick(); gap++; end while (tx_str !== 1'b1 && gap < 40);
        chk("retry_gap", 16'(gap), 16'd16);
        chk("err_set", 16'(err), 16'd1);
        wait_ready();
        chk("err_sticky", 16'(err), 16'd1);
        expect_pair("retry_a", 16'h055A);
        expect_pair("retry_b", 16'h055A);
        resp_delay = 0;

        init_req = 1'b1; tick();
        init_req = 1'b0; tick();
        chk("reinit_err_clr", 16'(err), 16'd0);
        chk("reinit_done_clr", 16'(init_done), 16'd0);
        expect_init();
        wait_ready();
        check_display("reinit");

        write_row(3'd1, 8'h42); tick();
        wr_en = 1'b0;
        wait_str(); tick(); tick();
        #1 rst = 1'b1;
        #1;
        chk("arst_str", 16'(tx_str), 16'd0);
        chk("arst_addr", 16'(tx_addr), 16'd0);
        chk("arst_data", 16'(tx_data), 16'd0);
        chk("arst_init_done", 16'(init_done), 16'd0);
        chk("arst_ready", 16'(ready), 16'd0);
        chk("arst_err", 16'(err), 16'd0);
        repeat (6) tick();
        q.delete();
        foreach (ref_buf[i]) ref_buf[i] = 8'h00;
        ref_int = 4'h8;
        rst = 1'b0;
        expect_init();
        wait_ready();

        for (int round = 0; round < 3; round++) begin
            for (int c = 0; c < 60; c++) begin
                tick();
                wr_en = $urandom_range(0, 2) == 0;
                wr_row = 3'($urandom);
                wr_data = 8'($urandom);
                if (wr_en) ref_buf[wr_row] = wr_data;
                intensity_we = $urandom_range(0, 9) == 0;
                intensity = 4'($urandom);
                if (intensity_we) ref_int = intensity;
            end
            tick();
            wr_en = 1'b0; intensity_we = 1'b0;
            wait_ready();
            while (q.size() > 0) get_pair(p);
            check_display($sformatf("rand%0d", round));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/max7219_ctrl.md
Name: max7219_ctrl

Overview:
Command sequencer for the MAX7219 serial driver of the 8x8 LED matrix. It holds an 8-row frame buffer and runs the MAX7219 power-up register sequence. It then streams only the rows that have changed, plus intensity updates, to the serial driver as (address, data) pairs, one transfer at a time. It sits between the display/game logic (row writes) and the serial driver (str/busy handshake).

Parameters:
INIT_INTENSITY, 4'h8, intensity sent during init and after reset
SCAN_LIMIT, 3'd7, value written to scan-limit register 0x0B
START_TIMEOUT, 8'd15, cycles to wait for driver busy to rise before re-issuing str

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
init_req  in  1  one-cycle pulse; re-run full init sequence, then mark all rows dirty
wr_en  in  1  frame buffer row write strobe
wr_row  in  3  row index 0..7
wr_data  in  8  row pixel bits, bit7 = column 0
intensity  in  4  new intensity value
intensity_we  in  1  latch intensity and schedule register 0x0A update
tx_busy  in  1  serial driver busy
tx_str  out  1  one-cycle start pulse to driver
tx_addr  out  8  MAX7219 register address, stable from tx_str until busy falls
tx_data  out  8  register data, same stability
init_done  out  1  high once init sequence completed
ready  out  1  init_done and no pending row/intensity updates and FSM in IDLE
err  out  1  sticky; set on start timeout, cleared by rst or init_req

Behaviour:
- Reset (async): tx_str=0, tx_addr=0, tx_data=0, init_done=0, ready=0, err=0. Frame buffer cleared, all 8 dirty bits set, intensity reg=INIT_INTENSITY, FSM=INIT_LOAD with init index 0. An in-flight driver transfer is abandoned; the controller does not wait for it.
- Init table (index 0..5): {0x0C,0x00} shutdown; {0x0F,0x00} test off; {0x09,0x00} no decode; {0x0B,{5'b0,SCAN_LIMIT}}; {0x0A,{4'b0,intensity_reg}}; {0x0C,0x01} normal op.
- FSM states: INIT_LOAD, IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
  - INIT_LOAD: drive the table entry to tx_addr/tx_data, go START.
  - IDLE: selection priority is (1) init_req pending, (2) intensity pending, (3) lowest-index dirty row. Row r is sent as address r+1 with data buf[r]. The dirty bit (or intensity pending flag) is cleared in the LOAD cycle, when the data is captured into tx_data.
  - LOAD: capture addr/data, go START.
  - START: tx_str=1 for exactly one cycle, clear timeout counter, go WAIT_BUSY.
  - WAIT_BUSY: on tx_busy=1 go WAIT_DONE. If the counter reaches START_TIMEOUT, set err and return to START (retry).
  - WAIT_DONE: on tx_busy=0, either advance the init index (after index 5, set init_done and go IDLE) or go IDLE.
- Latency: IDLE to tx_str is 2 cycles (LOAD, START). Back-to-back transfers have a minimum 3-cycle gap after busy falls.
- A write to a row in the same cycle its dirty bit is cleared: the set wins (row re-sent later). Writes are accepted in every state.
- intensity_we during init: the new value is latched. If index 4 has not yet been sent, the new value is used there; otherwise an intensity update is scheduled after init.
- init_req mid-transfer: latched as pending and acted on only from IDLE or after the current WAIT_DONE. It restarts at index 0, clears init_done and err, and sets all dirty bits.
- Width rules: row address = {5'b0, r} + 1, so it never wraps.

Decomposition:
- Shared package: MAX7219 register address constants (NOOP 0x00, DIGIT0 0x01, DECODE 0x09, INTENSITY 0x0A, SCANLIM 0x0B, SHUTDOWN 0x0C, TEST 0x0F), FSM state encoding, init table length 6.
- One sub-module: max7219_rowbuf (8x8 register file with dirty bits and a lowest-set priority encoder).

Test Plan:
- Reset release with a driver model (busy high 3 cycles after str): observe 6 init pairs 0C00,0F00,0900,0B07,0A08,0C01. Then 8 row pairs 0100..0800, after which init_done=1 and ready=1.
- After ready, write row 3=0xA5 and row 0=0x3C in consecutive cycles: expect 013C then 04A5, then ready=1 again.
- Write row 5 with 0x11 exactly in the LOAD cycle of row 5 (old value 0x00): expect 0600 followed by 0611.
- intensity_we with 4'hF while a row transfer is in flight: after it completes, expect 0A0F before any other dirty row.
- Driver model holds busy low for 20 cycles after str: expect err=1 and tx_str re-pulsed 16 cycles after the first. Once busy responds, the transfer completes and err stays set until init_req.
- Assert rst mid-WAIT_DONE: all outputs go to 0 immediately. After release, the full init sequence replays from 0C00.
